brick_hit_manager: RTL
======================

// Module: brick_hit_manager
// PURPOSE
//  Consumes the per-brick and paddle collision levels from the collision detector.
//  Owns the brick alive vector fed back to the detector and renderer, and keeps the score.
//  Emits one-cycle bounce pulses to the ball mover and flags level clear.
//  Sits between collision detection (upstream) and ball motion / VGA draw (downstream).
// PARAMETERS
//  NUM_BRICKS    10  number of bricks; alive bit i = brick i (0-4 top row, 5-9 bottom)
//  SCORE_W       12  score width
//  POINTS        10  score added per accepted brick hit
//  COOLDOWN_CYC  4   cycles after a hit with brick hits masked; legal range 2..255
//  TOUGH_ROW     5   bricks with index < TOUGH_ROW are two-hit (only with TWO_HIT_EN)
// PORTS
//  clk            in   1           system clock
//  rst            in   1           reset, asynchronous, active-high
//  game_start     in   1           1-cycle pulse: restore all bricks, clear score
//  collide_block  in   NUM_BRICKS  level; bit i high while ball overlaps brick i
//  collide_paddle in   1           level; high while ball overlaps paddle
//  alive          out  NUM_BRICKS  brick present mask
//  hit_valid      out  1           1-cycle pulse: brick hit accepted
//  hit_idx        out  4           index of accepted brick; held until next hit
//  bounce_y       out  1           1-cycle pulse: ball must invert Y velocity
//  score          out  SCORE_W     running score, saturating
//  level_clear    out  1           high while every brick is dead after play
// BEHAVIOUR
//  Reset: alive=0, hit_valid=0, hit_idx=0, bounce_y=0, score=0, level_clear=0.
//  Reset also clears the edge registers and the cooldown counter; FSM goes to IDLE.
//  Reset mid-game aborts immediately; no pulse issues during or on the first cycle after reset.
//  Edge detection: prev_blk and prev_pad are registered copies of the inputs.
//  - new_hit[i] = collide_block[i] & ~prev_blk[i] & alive[i]
//  - new_pad = collide_paddle & ~prev_pad
//  - A level held high counts exactly once.
//  FSM states IDLE, PLAY, COOL, CLEAR:
//  - IDLE: alive=0. On game_start: alive=all ones, score=0, go to PLAY.
//  - PLAY: if any new_hit, accept the lowest index i only. Other simultaneous hits are
//    dropped. At the next edge:
//    - hit_valid=1, bounce_y=1, hit_idx=i
//    - score=min(score+POINTS, 2^SCORE_W-1)
//    - the brick is decremented or killed
//    - cnt=COOLDOWN_CYC-1, go to COOL
//  - COOL: brick hits ignored; cnt decrements each cycle. When cnt==0:
//    - go to CLEAR if alive==0
//    - otherwise go to PLAY
//  - CLEAR: level_clear=1. On game_start: reload as from IDLE, level_clear=0, go to PLAY.
//  Latency: collide edge at cycle T -> hit_valid, bounce_y and alive update at T+1.
//  Paddle: new_pad in PLAY or COOL gives bounce_y=1 at the next edge.
//  - Paddle is not masked by cooldown.
//  - Brick and paddle in the same cycle give a single bounce_y pulse; hit_valid still
//    fires for the brick.
//  - New_pad is ignored in IDLE and CLEAR.
//  game_start has priority over any same-cycle hit or paddle event in every state.
//  - In PLAY or COOL it restarts: alive=all ones, score=0, cnt=0, go to PLAY, no pulses.
//  Outputs are registered; no combinational path from inputs to outputs.
// CONFIGURATION
//  TWO_HIT_EN defined:
//  - Per-brick 2-bit hits_left register.
//  - game_start loads 2 for index < TOUGH_ROW and 1 for all others.
//  - An accepted hit decrements hits_left; alive[i] clears when it reaches 0.
//  - Every accepted hit pulses hit_valid and bounce_y and adds POINTS.
//  TWO_HIT_EN undefined:
//  - No hits_left storage; every accepted hit clears alive[i].
//  - TOUGH_ROW is unused.
// TESTING
//  - Reset, then game_start -> alive=10'h3FF, score=0, FSM in PLAY, no pulses.
//  - collide_block=10'h010 for 1 cycle at T -> at T+1: hit_valid=1, bounce_y=1, hit_idx=4,
//    alive=10'h3EF, score=10.
//  - collide_block=10'h022 in one cycle -> hit_idx=1 only.
//    A new brick-5 edge 2 cycles later is ignored (COOL) -> alive=10'h3FD.
//  - Hold collide_block[0] high 20 cycles -> exactly 1 hit_valid (TWO_HIT_EN: still 1 hit).
//    Later collide_paddle edge in COOL -> bounce_y=1.
//  - Kill all 10 bricks -> level_clear=1 once COOL expires, score=100.
//    game_start -> level_clear=0, alive=10'h3FF.
//  - TWO_HIT_EN: 2 separated edges on brick 2 -> alive[2] stays 1 after first, 0 after
//    second, score=20. Assert rst mid-COOL -> all outputs 0 next cycle.

Source files
------------

// File: rtl/brick_hit_manager.sv
// Brick hit manager: turns collision levels into accepted brick hits, bounce pulses,
// a saturating score and level-clear. Optional two-hit top row via `define TWO_HIT_EN.
module brick_hit_manager #(
  parameter int NUM_BRICKS   = 10,
  parameter int SCORE_W      = 12,
  parameter int POINTS       = 10,
  parameter int COOLDOWN_CYC = 4
`ifdef TWO_HIT_EN
  ,
  parameter int TOUGH_ROW    = 5
`endif
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  game_start,
  input  logic [NUM_BRICKS-1:0] collide_block,
  input  logic                  collide_paddle,
  output logic [NUM_BRICKS-1:0] alive,
  output logic                  hit_valid,
  output logic [3:0]            hit_idx,
  output logic                  bounce_y,
  output logic [SCORE_W-1:0]    score,
  output logic                  level_clear
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] PLAY  = 2'd1;
  localparam logic [1:0] COOL  = 2'd2;
  localparam logic [1:0] CLEAR = 2'd3;

  localparam logic [SCORE_W:0] POINTS_EXT = (SCORE_W+1)'(POINTS);
  localparam logic [7:0]       COOL_LOAD  = 8'(COOLDOWN_CYC - 1);
  localparam logic [NUM_BRICKS-1:0] ONE_VEC = {{(NUM_BRICKS-1){1'b0}}, 1'b1};

  logic [1:0]            state;
  logic [7:0]            cnt;
  logic [NUM_BRICKS-1:0] prev_blk;
  logic                  prev_pad;

  logic [NUM_BRICKS-1:0] new_hit;
  logic [NUM_BRICKS-1:0] first_hit;
  logic [NUM_BRICKS-1:0] dead_mask;
  logic [3:0]            first_idx;
  logic                  new_pad;
  logic                  accept;
  logic [SCORE_W:0]      score_sum;
  logic [SCORE_W-1:0]    score_next;

`ifdef TWO_HIT_EN
  logic [1:0] hits_left [NUM_BRICKS];
`endif

  // Rising-edge detect per brick, lowest-index winner isolated as a one-hot mask.
  always_comb begin
    new_hit   = collide_block & ~prev_blk & alive;
    new_pad   = collide_paddle & ~prev_pad;
    first_hit = new_hit & (~new_hit + ONE_VEC);
    first_idx = 4'd0;
    for (int i = NUM_BRICKS - 1; i >= 0; i--) begin
      if (new_hit[i]) first_idx = 4'(i);
    end
    accept     = (state == PLAY) && !game_start && (|new_hit);
    score_sum  = {1'b0, score} + POINTS_EXT;
    score_next = score_sum[SCORE_W] ? {SCORE_W{1'b1}} : score_sum[SCORE_W-1:0];
  end

`ifdef TWO_HIT_EN
  always_comb begin
    dead_mask = '0;
    for (int i = 0; i < NUM_BRICKS; i++) begin
      dead_mask[i] = first_hit[i] && (hits_left[i] == 2'd1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_BRICKS; i++) hits_left[i] <= 2'd0;
    end else if (game_start) begin
      for (int i = 0; i < NUM_BRICKS; i++) hits_left[i] <= (i < TOUGH_ROW) ? 2'd2 : 2'd1;
    end else if (accept) begin
      for (int i = 0; i < NUM_BRICKS; i++) begin
        if (first_hit[i]) hits_left[i] <= hits_left[i] - 2'd1;
      end
    end
  end
`else
  always_comb begin
    dead_mask = first_hit;
  end
`endif

  // game_start overrides everything; pulses default low so they last one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= 8'd0;
      prev_blk    <= '0;
      prev_pad    <= 1'b0;
      alive       <= '0;
      hit_valid   <= 1'b0;
      hit_idx     <= 4'd0;
      bounce_y    <= 1'b0;
      score       <= '0;
      level_clear <= 1'b0;
    end else begin
      prev_blk  <= collide_block;
      prev_pad  <= collide_paddle;
      hit_valid <= 1'b0;
      bounce_y  <= 1'b0;
      if (game_start) begin
        state       <= PLAY;
        alive       <= '1;
        score       <= '0;
        cnt         <= 8'd0;
        level_clear <= 1'b0;
      end else begin
        case (state)
          PLAY: begin
            if (accept) begin
              hit_valid <= 1'b1;
              bounce_y  <= 1'b1;
              hit_idx   <= first_idx;
              score     <= score_next;
              alive     <= alive & ~dead_mask;
              cnt       <= COOL_LOAD;
              state     <= COOL;
            end else if (new_pad) begin
              bounce_y <= 1'b1;
            end
          end
          COOL: begin
            bounce_y <= new_pad;
            if (cnt == 8'd0) begin
              if (alive == '0) begin
                state       <= CLEAR;
                level_clear <= 1'b1;
              end else begin
                state <= PLAY;
              end
            end else begin
              cnt <= cnt - 8'd1;
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

endmodule
